fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the ARMv8 core. It owns the architectural fetch PC and issues in-order word requests to instruction memory. It buffers returned instructions with their PCs in a small prefetch queue and hands them to the decode/control stage through a valid/ready pair. Branch redirects from the execute stage flush the queue and discard stale in-flight responses.

## Interface
- INITPC, 64'h0000000000000000, fetch PC loaded on reset
- DEPTH, 4, prefetch queue entries; also the max in-flight requests (power of two, 2..16)

- clk  in  1  core clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  64  word-aligned fetch address
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response word present (in request order, ≥1 cycle after accept)
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  branch taken / PC override this cycle
- redirect_pc  in  64  new fetch PC; bits [1:0] ignored (treated as 0)
- halt  in  1  level; stop issuing new requests
- out_valid  out  1  out_instr/out_pc valid
- out_instr  out  32  instruction at queue head
- out_pc  out  64  PC of out_instr
- out_ready  in  1  consumer takes head this cycle

## Operation
- Registers: fetch_pc (next request address), rsp_pc (PC of next kept response), occupancy count, in-flight count, drop count, queue storage {instr, pc} × DEPTH with wrap-around read and write pointers.
- Issue: imem_req_valid = !halt && !redirect-pending-state && (occupancy + inflight < DEPTH). It does not depend combinationally on redirect_valid. On accept (valid && ready), fetch_pc += 4 and inflight += 1.
- Response: each imem_rsp_valid decrements inflight.
  - If drop > 0, the word is discarded and drop -= 1.
  - Otherwise, {data, rsp_pc} is pushed and rsp_pc += 4.
  - The credit rule guarantees the queue never overflows. A response arriving at full occupancy is impossible; the bench asserts on it.
- Pop: when out_valid && out_ready, the head is removed. Pop and push in the same cycle leave occupancy unchanged, including at full and at empty (a push into an empty queue is not bypassed).
- Redirect (highest priority):
  - fetch_pc ← {redirect_pc[63:2], 2'b00} and rsp_pc ← the same value.
  - Occupancy ← 0 and pointers ← 0.
  - drop ← inflight_next, i.e. every request outstanding after this cycle, including one accepted and excluding a response received this cycle. Any response in the redirect cycle is discarded.
  - A pop in the redirect cycle still completes, so the consumer sees the old head accepted.
- Halt: only blocks new requests. In-flight responses still land, and the queue still drains. Deasserting halt resumes from fetch_pc.
- Arithmetic: PCs are 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0. Counters are $clog2(DEPTH)+1 bits wide.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr INITPC, out_valid 0, out_instr 0, out_pc 0, all counts 0.
- First request is issued in the first cycle after reset deasserts, with addr INITPC.
- Latency: a response received in cycle N is visible on out_valid in cycle N+1.
- Redirect in cycle N:
  - out_valid is 0 in N+1.
  - The request for redirect_pc is presented in N+1.
  - The first kept instruction appears no earlier than (its response cycle)+1.
- Reset asserted mid-operation: immediate return to reset values. Responses arriving after reset deassertion that belong to pre-reset requests are the memory's responsibility; memory is reset by the same signal.
- Throughput: one instruction per cycle sustained when memory returns one response per cycle and out_ready = 1.

## Configuration
- FETCH_PERF_EN defined: adds output perf_fetched[31:0], kept responses pushed, and output perf_flushed[31:0], entries discarded (queue occupancy at redirect plus dropped responses). Both reset to 0 and wrap modulo 2^32.
- Not defined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- Reset release, memory always ready, 1-cycle response, out_ready=1 -> out_pc sequence 0,4,8,12…, one per cycle from cycle 3 on; out_instr matches memory words.
- out_ready=0 held -> exactly DEPTH=4 requests issued, then imem_req_valid=0; out_valid=1 with out_pc=0 held. Releasing out_ready drains 0,4,8,12 then resumes at 16.
- Redirect to 0x1002 while 2 requests are in flight -> both stale responses dropped; next out_pc=0x1000, then 0x1004. Queue contents before the redirect are never presented.
- halt=1 for 10 cycles -> no new requests, queued entries still drain. On halt=0 the next imem_req_addr continues from the last issued + 4.
- Wrap: INITPC=64'hFFFF_FFFF_FFFF_FFF8 -> out_pc FFF8, FFFC, 0, 4.
- With FETCH_PERF_EN, 3 queued and 1 in flight at redirect -> perf_flushed increments by 4; perf_fetched counts only kept words.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a credit-limited prefetch queue.
// Define FETCH_PERF_EN to add the perf_fetched/perf_flushed counters.
module fetch_unit #(
  parameter logic [63:0] INITPC = 64'h0,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [63:0]   fpc_q, fpc_d;
  logic [63:0]   rpc_q, rpc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [31:0]   instr_q [DEPTH];
  logic [63:0]   pc_q [DEPTH];

  logic          req_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic [63:0]   redir_pc;
  logic [CW:0]   credit;

  assign redir_pc = redirect_pc & ~64'h3;
  assign credit   = {1'b0, occ_q} + {1'b0, infl_q};

  // Every request needs a queue slot reserved for its response.
  assign imem_req_valid = !reset && !halt &&
                          (credit < {1'b0, DEPTH_C});
  assign imem_req_addr  = fpc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = occ_q != '0;
  assign out_instr = out_valid ? instr_q[rd_q] : '0;
  assign out_pc    = out_valid ? pc_q[rd_q] : '0;
  assign pop       = out_valid && out_ready;

  assign rsp_drop = imem_rsp_valid &&
                    (redirect_valid || drop_q != '0);
  assign push     = imem_rsp_valid && !rsp_drop;

  always_comb begin
    infl_d = infl_q;
    if (req_fire)       infl_d = infl_d + ONE;
    if (imem_rsp_valid) infl_d = infl_d - ONE;
    fpc_d  = fpc_q;
    rpc_d  = rpc_q;
    occ_d  = occ_q;
    drop_d = drop_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (redirect_valid) begin
      fpc_d  = redir_pc;
      rpc_d  = redir_pc;
      occ_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      drop_d = infl_d;
    end else begin
      if (req_fire) fpc_d = fpc_q + 64'd4;
      if (imem_rsp_valid && drop_q != '0)
        drop_d = drop_q - ONE;
      if (push) begin
        rpc_d = rpc_q + 64'd4;
        wr_d  = wr_q + PONE;
      end
      if (pop) rd_d = rd_q + PONE;
      if (push && !pop)
        occ_d = occ_q + ONE;
      else if (pop && !push)
        occ_d = occ_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q  <= INITPC;
      rpc_q  <= INITPC;
      occ_q  <= '0;
      infl_q <= '0;
      drop_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      fpc_q  <= fpc_d;
      rpc_q  <= rpc_d;
      occ_q  <= occ_d;
      infl_q <= infl_d;
      drop_q <= drop_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      if (push) begin
        instr_q[wr_q] <= imem_rsp_data;
        pc_q[wr_q]    <= rpc_q;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] flushed_q, flushed_d;

  // A head popped in the redirect cycle was consumed, not discarded.
  always_comb begin
    fetched_d = fetched_q + (push ? 32'd1 : 32'd0);
    flushed_d = flushed_q + (rsp_drop ? 32'd1 : 32'd0);
    if (redirect_valid)
      flushed_d = flushed_d + 32'(occ_q) -
                  (pop ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with an in-order memory model for fetch_unit.
// A per-cycle vector table covers the stall/drain sequence.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int D = 4;
  localparam logic [63:0] IPC = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  fetch_unit #(.INITPC(IPC), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_ready(out_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    int          due;
    int          ep;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] w;
  } ent_t;

  typedef struct {
    logic        ordy;
    logic        rv;
    logic [63:0] ra;
    logic        ov;
    logic [63:0] opc;
  } vec_t;

  req_t        pend[$];
  ent_t        sb[$];
  logic [63:0] plog[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ep = 0;
  int          lat = 1;
  int          kept = 0;
  int          flushed = 0;
  int          nfire = 0;
  logic [63:0] efpc;
  logic        s_ordy, s_halt, s_rdy, s_rv;
  logic [63:0] s_rpc;

  function automatic logic [31:0] word(logic [63:0] a);
    return (a[31:0] ^ 32'hC001_D00D) + a[63:32];
  endfunction

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               n, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check, update model, advance.
  task automatic tick();
    bit   rsp, fire, pop;
    int   occ0;
    req_t r;
    rsp = pend.size() != 0 && pend[0].due <= cyc;
    out_ready      = s_ordy;
    halt           = s_halt;
    imem_req_ready = s_rdy;
    redirect_valid = s_rv;
    redirect_pc    = s_rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? word(pend[0].a) : '0;
    #1;
    occ0 = sb.size();
    chk("out_valid", out_valid, occ0 != 0);
    if (occ0 != 0) begin
      chk("out_pc", out_pc, sb[0].pc);
      chk("out_instr", out_instr, sb[0].w);
    end
    chk("req_valid", imem_req_valid,
        !s_halt && (occ0 + pend.size() < D));
    chk("req_addr", imem_req_addr, efpc);
    fire = imem_req_valid && imem_req_ready;
    pop  = out_valid && out_ready;
    if (pop && sb.size() != 0) begin
      plog.push_back(sb[0].pc);
      void'(sb.pop_front());
    end
    if (rsp) begin
      r = pend.pop_front();
      chk("rsp_room", occ0 < D, 1'b1);
      if (r.ep == ep && !s_rv) begin
        sb.push_back('{r.a, word(r.a)});
        kept++;
      end else begin
        flushed++;
      end
    end
    if (s_rv) flushed += sb.size();
    if (fire) begin
      pend.push_back('{efpc, cyc + lat, ep});
      efpc += 64'd4;
      nfire++;
    end
    if (s_rv) begin
      sb.delete();
      ep++;
      efpc = s_rpc & ~64'h3;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_ordy = 0; s_halt = 0; s_rdy = 1; s_rv = 0; s_rpc = '0;
    out_ready = 0; halt = 0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, IPC);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 64'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_flushed", perf_flushed, 32'h0);
`endif
    pend.delete();
    sb.delete();
    efpc = IPC;
    kept = 0;
    flushed = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vec_t        tab[12];
    logic [63:0] wexp[4];
    logic [63:0] la;
    int          m, n, p0, nf0;

    // ordy, req_valid, req_addr, out_valid, out_pc
    tab[0]  = '{1'b0, 1'b1, 64'd0,  1'b0, 64'd0};
    tab[1]  = '{1'b0, 1'b1, 64'd4,  1'b0, 64'd0};
    tab[2]  = '{1'b0, 1'b1, 64'd8,  1'b1, 64'd0};
    tab[3]  = '{1'b0, 1'b1, 64'd12, 1'b1, 64'd0};
    tab[4]  = '{1'b0, 1'b0, 64'd16, 1'b1, 64'd0};
    tab[5]  = '{1'b0, 1'b0, 64'd16, 1'b1, 64'd0};
    tab[6]  = '{1'b0, 1'b0, 64'd16, 1'b1, 64'd0};
    tab[7]  = '{1'b1, 1'b0, 64'd16, 1'b1, 64'd0};
    tab[8]  = '{1'b1, 1'b1, 64'd16, 1'b1, 64'd4};
    tab[9]  = '{1'b1, 1'b1, 64'd20, 1'b1, 64'd8};
    tab[10] = '{1'b1, 1'b1, 64'd24, 1'b1, 64'd12};
    tab[11] = '{1'b1, 1'b1, 64'd28, 1'b1, 64'd16};

    reset = 1'b0;
    #2;
    do_reset();

    lat = 1;
    for (int i = 0; i < 12; i++) begin
      s_ordy = tab[i].ordy;
      out_ready = s_ordy;
      #1;
      chk($sformatf("vec%0d_req_valid", i),
          imem_req_valid, tab[i].rv);
      chk($sformatf("vec%0d_req_addr", i),
          imem_req_addr, tab[i].ra);
      chk($sformatf("vec%0d_out_valid", i),
          out_valid, tab[i].ov);
      chk($sformatf("vec%0d_out_pc", i), out_pc, tab[i].opc);
      tick();
    end

    p0 = plog.size();
    repeat (16) tick();
    chk("throughput", plog.size() - p0, 16);

    // Redirect with two stale requests outstanding.
    do_reset();
    lat = 3;
    s_ordy = 1;
    n = 0;
    while (pend.size() != 2 && n < 20) begin
      tick();
      n++;
    end
    chk("redir_setup_inflight", pend.size(), 2);
    s_rv = 1; s_rpc = 64'h1002; s_rdy = 0;
    tick();
    chk("redir_out_valid_n1", out_valid, 1'b0);
    s_rv = 0; s_rdy = 1;
    m = plog.size();
    repeat (12) tick();
    chk("redir_pops", plog.size() >= m + 2, 1'b1);
    if (plog.size() >= m + 2) begin
      chk("redir_first_pc", plog[m], 64'h1000);
      chk("redir_second_pc", plog[m+1], 64'h1004);
    end

    // Halt blocks issue but lets the queue drain.
    la = efpc;
    nf0 = nfire;
    s_halt = 1;
    repeat (10) tick();
    chk("halt_no_issue", nfire - nf0, 0);
    chk("halt_drained", out_valid, 1'b0);
    chk("halt_resume_addr", imem_req_addr, la);
    s_halt = 0;
    tick();
    chk("halt_resume_fire", nfire - nf0, 1);

    // PC wrap through 2^64.
    lat = 1;
    s_rv = 1; s_rpc = 64'hFFFF_FFFF_FFFF_FFF9;
    tick();
    s_rv = 0;
    m = plog.size();
    repeat (10) tick();
    wexp[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    wexp[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    wexp[2] = 64'h0;
    wexp[3] = 64'h4;
    chk("wrap_pops", plog.size() >= m + 4, 1'b1);
    if (plog.size() >= m + 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("wrap_pc%0d", i), plog[m+i], wexp[i]);

`ifdef FETCH_PERF_EN
    do_reset();
    lat = 1;
    s_ordy = 0;
    n = 0;
    while (!(sb.size() == 3 && pend.size() == 1) && n < 20) begin
      tick();
      n++;
    end
    chk("perf_setup", sb.size() * 10 + pend.size(), 31);
    p0 = perf_flushed;
    s_rv = 1; s_rpc = 64'h2000;
    tick();
    s_rv = 0;
    repeat (3) tick();
    chk("perf_flushed_delta", perf_flushed - p0, 4);
    chk("perf_fetched", perf_fetched, kept);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) lat = $urandom_range(3, 1);
      s_ordy = $urandom_range(1, 0);
      s_rdy  = $urandom_range(3, 0) != 0;
      s_halt = $urandom_range(9, 0) == 0;
      s_rv   = $urandom_range(19, 0) == 0;
      s_rpc  = {$urandom, $urandom};
      tick();
    end
    s_rv = 0; s_halt = 0;
`ifdef FETCH_PERF_EN
    chk("rand_perf_fetched", perf_fetched, kept);
    chk("rand_perf_flushed", perf_flushed, flushed);
`endif

    // Asynchronous reset in the middle of traffic.
    s_ordy = 1; s_rdy = 1; lat = 1;
    repeat (5) tick();
    #2;
    do_reset();
    s_ordy = 1;
    repeat (8) tick();
    chk("post_reset_pops", plog.size() > 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
